responder_round_ctrl: RTL
=========================

// Module: responder_round_ctrl
// PURPOSE
//  Round controller for the quiz responder. Arbitrates first-press among
//  player keys, runs the BCD answer-window countdown and latches the winner.
//  Drives Player_Number/TimerH/TimerL of the seven-segment display mux and
//  the buzzer. Sits between the debounced key inputs and the display module.
// PARAMETERS
//  NUM_PLAYERS  8    player keys; 1..9 (players shown as 1..NUM_PLAYERS, 0 = none)
//  TICK_DIV     50000000  CLK cycles per countdown second; >=2
//  TIME_INIT    30   countdown start value in seconds; 1..99
//  BUZZ_CYCLES  1000 buzzer pulse length in CLK cycles; >=1
// PORTS
//  CLK            in   1            system clock
//  RSTn           in   1            async reset, active low
//  Host_Start     in   1            host start key, active high, debounced
//  Host_Clear     in   1            host clear key, active high, debounced
//  Player_Key     in   NUM_PLAYERS  player keys, active high, debounced
//  Player_Number  out  4            latched player number, 0 = none
//  TimerH         out  4            countdown tens digit (BCD)
//  TimerL         out  4            countdown units digit (BCD)
//  Buzzer         out  1            buzzer pulse
//  Round_Active   out  1            high while countdown running
//  Foul           out  1            high after a press before start
// BEHAVIOUR
//  - One clock CLK; RSTn asynchronous, active low. All regs registered outputs.
//  - Reset: state IDLE, Player_Number=0, TimerH/TimerL=TIME_INIT/10,%10,
//    Buzzer=0, Round_Active=0, Foul=0, sync/edge flops=0, tick count=0.
//  - All inputs: 2-flop sync then rising-edge detect (event = s1 & ~prev).
//    Pin to event latency 3 cycles; state update on the following edge.
//    Key held through reset yields one event after reset release.
//  - States: IDLE, ARMED, ANSWER, TIMEOUT, FOUL.
//  - Clear event: highest priority in every state -> IDLE, timer reloaded,
//    Player_Number=0, Foul=0, Buzzer=0, tick count=0. Beats Start same cycle.
//  - IDLE: Start event -> ARMED, tick count=0. Any key event -> FOUL.
//    Key and Start events same cycle -> FOUL.
//  - ARMED: Round_Active=1. Tick count 0..TICK_DIV-1; at TICK_DIV-1 it wraps
//    and timer decrements: TimerL==0 ? (TimerL=9, TimerH-1) : TimerL-1.
//    Decrement reaching 00 -> TIMEOUT. Key event -> ANSWER, timer frozen.
//  - Arbitration: several key events same cycle -> lowest index wins;
//    Player_Number = index+1. Key event and tick same cycle -> key wins,
//    no decrement (also when the decrement would reach 00).
//  - ANSWER: timer, Player_Number frozen; further keys and Start ignored.
//  - TIMEOUT: timer 00, Player_Number=0; keys and Start ignored.
//  - FOUL: Foul=1, Player_Number = lowest-index offender; timer at TIME_INIT;
//    keys and Start ignored.
//  - Entry to ANSWER/TIMEOUT/FOUL: Buzzer high exactly BUZZ_CYCLES cycles,
//    starting the cycle the new state is visible. Round_Active=0 there.
//  - RSTn asserted mid-round: all outputs return to reset values immediately.
// TESTING (TICK_DIV=4, TIME_INIT=30, BUZZ_CYCLES=5, NUM_PLAYERS=8)
//  1 Reset -> Player_Number=0, TimerH=3, TimerL=0, Buzzer/Round_Active/Foul=0.
//  2 Start, 3 ticks, pulse key 3 -> Player_Number=4, timer 27 frozen,
//    Buzzer high 5 cycles, Round_Active=0; later key 5 press ignored.
//  3 Start, keys 2 and 5 same cycle -> Player_Number=3; key on tick cycle ->
//    no decrement.
//  4 Start, no keys -> 30,29,..,10,09 (borrow),..,00 -> TIMEOUT, Buzzer 5 cycles.
//  5 Key 0 in IDLE -> FOUL, Foul=1, Player_Number=1; Start ignored; Clear -> IDLE.
//  6 Clear+Start same cycle in ANSWER -> IDLE, timer 30; RSTn low mid-ARMED
//    -> reset values at once.

Source files
------------

// File: rtl/responder_round_ctrl.sv
// rtl/responder_round_ctrl.sv - quiz responder round controller
// First-press arbitration, BCD answer countdown, winner latch and buzzer pulse.
module responder_round_ctrl #(
    parameter int NUM_PLAYERS = 8,
    parameter int TICK_DIV    = 50000000,
    parameter int TIME_INIT   = 30,
    parameter int BUZZ_CYCLES = 1000
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   Host_Start,
    input  logic                   Host_Clear,
    input  logic [NUM_PLAYERS-1:0] Player_Key,
    output logic [3:0]             Player_Number,
    output logic [3:0]             TimerH,
    output logic [3:0]             TimerL,
    output logic                   Buzzer,
    output logic                   Round_Active,
    output logic                   Foul
);
    localparam int NIN = NUM_PLAYERS + 2;
    localparam int TW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BW  = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);
    localparam logic [3:0]    INIT_H    = 4'(TIME_INIT / 10);
    localparam logic [3:0]    INIT_L    = 4'(TIME_INIT % 10);

    typedef enum logic [2:0] {IDLE, ARMED, ANSWER, TIMEOUT, FOUL} state_t;

    // Input vector layout: {clear, start, keys}
    logic [NIN-1:0] sync0_q, sync1_q, prev_q, event_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync0_q <= '0;
            sync1_q <= '0;
            prev_q  <= '0;
            event_q <= '0;
        end else begin
            sync0_q <= {Host_Clear, Host_Start, Player_Key};
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
            event_q <= sync1_q & ~prev_q;
        end
    end

    logic                   clear_ev, start_ev;
    logic [NUM_PLAYERS-1:0] key_ev;
    logic [3:0]             winner;

    assign {clear_ev, start_ev, key_ev} = event_q;

    always_comb begin
        winner = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (key_ev[i]) winner = 4'(i + 1);
        end
    end

    state_t        state_q, state_d;
    logic [3:0]    pn_q, pn_d, th_q, th_d, tl_q, tl_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
    logic          buzz_q, buzz_d, act_q, act_d, foul_q, foul_d;
    logic          alarm;

    always_comb begin
        state_d    = state_q;
        pn_d       = pn_q;
        th_d       = th_q;
        tl_d       = tl_q;
        tick_d     = tick_q;
        buzz_d     = buzz_q;
        buzz_cnt_d = buzz_cnt_q;
        alarm      = 1'b0;

        if (buzz_q) begin
            if (buzz_cnt_q == '0) buzz_d = 1'b0;
            else                  buzz_cnt_d = buzz_cnt_q - 1'b1;
        end

        if (clear_ev) begin
            state_d    = IDLE;
            pn_d       = '0;
            th_d       = INIT_H;
            tl_d       = INIT_L;
            tick_d     = '0;
            buzz_d     = 1'b0;
            buzz_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|key_ev) begin
                        state_d = FOUL;
                        pn_d    = winner;
                        alarm   = 1'b1;
                    end else if (start_ev) begin
                        state_d = ARMED;
                        tick_d  = '0;
                    end
                end
                ARMED: begin
                    // A key press on the tick cycle wins and freezes the timer.
                    if (|key_ev) begin
                        state_d = ANSWER;
                        pn_d    = winner;
                        alarm   = 1'b1;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (tl_q == 4'd0) begin
                            tl_d = 4'd9;
                            th_d = th_q - 1'b1;
                        end else begin
                            tl_d = tl_q - 1'b1;
                        end
                        if (th_q == 4'd0 && tl_q == 4'd1) begin
                            state_d = TIMEOUT;
                            alarm   = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (alarm) begin
            buzz_d     = 1'b1;
            buzz_cnt_d = BUZZ_LAST;
        end

        act_d  = (state_d == ARMED);
        foul_d = (state_d == FOUL);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            pn_q       <= '0;
            th_q       <= INIT_H;
            tl_q       <= INIT_L;
            tick_q     <= '0;
            buzz_q     <= 1'b0;
            buzz_cnt_q <= '0;
            act_q      <= 1'b0;
            foul_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pn_q       <= pn_d;
            th_q       <= th_d;
            tl_q       <= tl_d;
            tick_q     <= tick_d;
            buzz_q     <= buzz_d;
            buzz_cnt_q <= buzz_cnt_d;
            act_q      <= act_d;
            foul_q     <= foul_d;
        end
    end

    assign Player_Number = pn_q;
    assign TimerH        = th_q;
    assign TimerL        = tl_q;
    assign Buzzer        = buzz_q;
    assign Round_Active  = act_q;
    assign Foul          = foul_q;
endmodule
